// File: rtl/alu_seq.sv
// Unsigned sequential ALU: single-cycle add/subtract, shift-add multiply and
// restoring divide (one bit per cycle), behind a start/ready/done handshake.
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic [WIDTH-1:0]     rem,
   output logic                 neg,
   output logic                 err
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state;
   logic [1:0]           op_r;
   logic [WIDTH-1:0]     a_r, b_r;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   acc;    // MUL partial product
   logic [2*WIDTH-1:0]   mcand;  // MUL multiplicand, shifted left each step
   logic [WIDTH-1:0]     sh;     // MUL multiplier / DIV dividend-becoming-quotient
   logic [WIDTH:0]       dr;     // DIV partial remainder

   logic [2*WIDTH-1:0]   a_x, b_x, mul_acc_nx;
   logic [WIDTH:0]       div_sh, div_r_nx;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_q_nx;

   assign a_x        = {{WIDTH{1'b0}}, a_r};
   assign b_x        = {{WIDTH{1'b0}}, b_r};
   assign mul_acc_nx = acc + (sh[0] ? mcand : '0);

   // Restoring step: bring in the next dividend bit, subtract divisor if it fits.
   assign div_sh   = {dr[WIDTH-1:0], sh[WIDTH-1]};
   assign div_ge   = (div_sh >= {1'b0, b_r});
   assign div_r_nx = div_ge ? (div_sh - {1'b0, b_r}) : div_sh;
   assign div_q_nx = {sh[WIDTH-2:0], div_ge};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         ready  <= 1'b1;
         done   <= 1'b0;
         result <= '0;
         rem    <= '0;
         neg    <= 1'b0;
         err    <= 1'b0;
         op_r   <= '0;
         a_r    <= '0;
         b_r    <= '0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         sh     <= '0;
         dr     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= CALC;
                  ready <= 1'b0;
                  op_r  <= op;
                  a_r   <= A;
                  b_r   <= B;
                  cnt   <= CW'(WIDTH);
                  acc   <= '0;
                  mcand <= {{WIDTH{1'b0}}, A};
                  sh    <= (op == OP_MUL) ? B : A;
                  dr    <= '0;
               end
            end

            CALC: begin
               case (op_r)
                  OP_ADD: begin
                     result <= a_x + b_x;
                     rem    <= '0;
                     neg    <= 1'b0;
                     err    <= 1'b0;
                     state  <= DONE;
                     done   <= 1'b1;
                  end
                  OP_SUB: begin
                     result <= (a_r >= b_r) ? (a_x - b_x) : (b_x - a_x);
                     rem    <= '0;
                     neg    <= (a_r < b_r);
                     err    <= 1'b0;
                     state  <= DONE;
                     done   <= 1'b1;
                  end
                  OP_MUL: begin
                     acc   <= mul_acc_nx;
                     mcand <= mcand << 1;
                     sh    <= sh >> 1;
                     cnt   <= cnt - CW'(1);
                     if (cnt == CW'(1)) begin
                        result <= mul_acc_nx;
                        rem    <= '0;
                        neg    <= 1'b0;
                        err    <= 1'b0;
                        state  <= DONE;
                        done   <= 1'b1;
                     end
                  end
                  default: begin
                     if (b_r == '0) begin
                        result <= '0;
                        rem    <= '0;
                        neg    <= 1'b0;
                        err    <= 1'b1;
                        state  <= DONE;
                        done   <= 1'b1;
                     end else begin
                        dr  <= div_r_nx;
                        sh  <= div_q_nx;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                           result <= {{WIDTH{1'b0}}, div_q_nx};
                           rem    <= div_r_nx[WIDTH-1:0];
                           neg    <= 1'b0;
                           err    <= 1'b0;
                           state  <= DONE;
                           done   <= 1'b1;
                        end
                     end
                  end
               endcase
            end

            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               ready <= 1'b1;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
